// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one combinational array multiplier among NUM_REQ
// requesters. It uses round-robin arbitration, a registered operand stage and
// a registered result stage with valid/ready backpressure. Each result carries
// the index of the requester that issued it.
// Optional build macro MULT_PIPE_EN inserts a product register (s2) between
// the multiplier and the output register. That adds one cycle of latency.

module mult_rr_array_mult #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  logic [N:0] acc;

  // Row-by-row shift-add array: each row adds one partial product to the
  // running sum and retires its low bit into the product.
  always_comb begin
    p      = '0;
    acc    = {1'b0, a & {N{b[0]}}};
    p[0]   = acc[0];
    for (int unsigned r = 1; r < N; r++) begin
      acc  = {1'b0, acc[N:1]} + {1'b0, a & {N{b[r]}}};
      p[r] = acc[0];
    end
    p[2*N-1:N] = acc[N:1];
  end

endmodule

module mult_rr_scheduler #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [2*N-1:0]       out_p,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready
);

  localparam int unsigned NR = NUM_REQ;

  logic            adv;
  logic            found;
  logic            hs;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr;

  logic            s1_valid;
  logic [N-1:0]    s1_a;
  logic [N-1:0]    s1_b;
  logic [ID_W-1:0] s1_id;
  logic [2*N-1:0]  prod;

`ifdef MULT_PIPE_EN
  logic            s2_valid;
  logic [2*N-1:0]  s2_p;
  logic [ID_W-1:0] s2_id;
`endif

  // The whole pipeline advances in lockstep whenever the output slot can drain.
  always_comb begin
    adv = !out_valid | out_ready;
  end

  // Round-robin search starting just after the last winner. The pointer itself
  // is checked last, so a lone active requester still wins every cycle.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      if (!found && req_valid[(32'(ptr) + k) % NR]) begin
        found  = 1'b1;
        winner = ID_W'((32'(ptr) + k) % NR);
      end
    end
  end

  // Grant only the winner, only when the pipeline can take it and not in reset.
  always_comb begin
    req_ready = '0;
    hs        = !rst && found && adv;
    if (hs) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Priority pointer moves to the last winner on every accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (hs) begin
      ptr <= winner;
    end
  end

  // Operand register captures the winner's operands and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (adv) begin
      s1_valid <= hs;
      s1_a     <= req_a[winner*N +: N];
      s1_b     <= req_b[winner*N +: N];
      s1_id    <= winner;
    end
  end

  mult_rr_array_mult #(.N(N)) u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

`ifdef MULT_PIPE_EN
  // Product register that breaks the multiplier path away from the output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_id    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_p     <= prod;
      s2_id    <= s1_id;
    end
  end

  // Output register that is fed by the product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_id    <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_p     <= s2_p;
      out_id    <= s2_id;
    end
  end
`else
  // Output register that is fed directly by the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_id    <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_p     <= prod;
      out_id    <= s1_id;
    end
  end
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler. It uses directed vectors followed by
// random traffic.
module tb_mult_rr_scheduler;

  localparam int N       = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [2*N-1:0]       out_p;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready;

  logic [N-1:0]   ta [NUM_REQ];
  logic [N-1:0]   tbv[NUM_REQ];
  logic [2*N-1:0] te [NUM_REQ];

  int checks = 0;
  int errors = 0;

  // Expected results in handshake order, stored as {id, product}.
  logic [ID_W+2*N-1:0] sb[$];

  mult_rr_scheduler #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_p     (out_p),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*N +: N] = ta[i];
      req_b[i*N +: N] = tbv[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer and pipeline occupancy.
  int   mptr = NUM_REQ - 1;
  logic m_s1v = 1'b0;
  logic m_s2v = 1'b0;
  logic m_ov  = 1'b0;
  logic m_adv;
  int   m_win;
  logic [NUM_REQ-1:0] m_rdy;

  // Predict the grant, check the grant and the output valid, and push on each handshake.
  always @(negedge clk) begin
    m_adv = !m_ov || out_ready;
    m_win = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (m_win < 0 && req_valid[(mptr + k) % NUM_REQ]) m_win = (mptr + k) % NUM_REQ;
    end
    m_rdy = '0;
    if (!rst && m_win >= 0 && m_adv) m_rdy[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (rst) begin
      mptr  = NUM_REQ - 1;
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      m_ov  = 1'b0;
      sb.delete();
    end else if (m_adv) begin
      if (m_rdy != '0) begin
        sb.push_back({ID_W'(m_win), te[m_win]});
        mptr = m_win;
      end
`ifdef MULT_PIPE_EN
      m_ov  = m_s2v;
      m_s2v = m_s1v;
`else
      m_ov  = m_s1v;
`endif
      m_s1v = (m_rdy != '0);
    end
  end

  logic           hold_v = 1'b0;
  logic [2*N-1:0] hold_p;
  logic [ID_W-1:0] hold_id;
  logic [ID_W+2*N-1:0] exp_e;

  // Compare each accepted result with the scoreboard, and check that the output holds steady under a stall.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_p", 32'(out_p), 32'(hold_p));
        chk("stall_id", 32'(out_id), 32'(hold_id));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          exp_e = sb.pop_front();
          chk("out_p", 32'(out_p), 32'(exp_e[2*N-1:0]));
          chk("out_id", 32'(out_id), 32'(exp_e[ID_W+2*N-1:2*N]));
        end
      end
      hold_v  = out_valid && !out_ready;
      hold_p  = out_p;
      hold_id = out_id;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] e);
    ta[i]  = a;
    tbv[i] = b;
    te[i]  = e;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, '0);
    step(3);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_p", 32'(out_p), 32'(0));
    chk("rst_out_id", 32'(out_id), 32'(0));
    rst = 1'b0;

    // A single request from requester 1 gives 13*11 = 143.
    set_req(1, 8'd13, 8'd11, 16'd143);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    step(4);

    // All requesters active from a fresh reset: products 10,20,30,40 in rotation.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(i + 1), 8'd10, 16'((i + 1) * 10));
    req_valid = 4'b1111;
    step(8);

    // Backpressure for 5 cycles, then resume.
    out_ready = 1'b0;
    step(5);
    out_ready = 1'b1;
    step(4);
    req_valid = '0;
    step(4);

    // Extreme operands.
    set_req(0, 8'd255, 8'd255, 16'hFE01);
    set_req(1, 8'd0,   8'd200, 16'h0000);
    set_req(2, 8'd1,   8'd255, 16'h00FF);
    req_valid = 4'b0111;
    step(3);
    req_valid = '0;
    step(4);

    // Reset one cycle after a handshake discards it and rewinds the pointer.
    set_req(0, 8'd3, 8'd4, 16'd12);
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_req(0, 8'd5, 8'd6, 16'd30);
    set_req(2, 8'd7, 8'd8, 16'd56);
    req_valid = 4'b0101;
    step(1);
    chk("post_rst_grant_hold", 32'(out_valid), 32'(0));
    step(1);
    req_valid = '0;
    step(4);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        ta[i]  = N'($urandom);
        tbv[i] = N'($urandom);
        te[i]  = 16'(ta[i]) * 16'(tbv[i]);
      end
      req_valid = NUM_REQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Drain with a bounded wait.
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) step(1);
    chk("drain_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
